// File: rtl/multiplier_sequencer_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the
// 4x4 column-by-column multiplier sequencer.
package multiplier_sequencer_pkg;

    localparam int OP_W     = 4;
    localparam int PROD_W   = 8;
    localparam int NUM_COLS = 7;

    localparam logic [2:0] SEL_ZERO = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/multiplier_sequencer_if.sv
// Operand, lane-select and result bundle between the sequencer and its
// requester / partial-product stage.
interface multiplier_sequencer_if;
    import multiplier_sequencer_pkg::*;

    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [OP_W-1:0]   ia;
    logic [OP_W-1:0]   ib;
    logic [2:0]        ctrl_b0;
    logic [2:0]        ctrl_b1;
    logic [2:0]        ctrl_b2;
    logic [2:0]        ctrl_b3;
    logic [3:0]        pp;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] p;

    modport slave (
        input  start, a, b, pp,
        output ia, ib, ctrl_b0, ctrl_b1, ctrl_b2, ctrl_b3, busy, done, p
    );

    modport master (
        output start, a, b, pp,
        input  ia, ib, ctrl_b0, ctrl_b1, ctrl_b2, ctrl_b3, busy, done, p
    );

endinterface

// File: rtl/multiplier_sequencer_column_select.sv
// Decodes the current product column into the four lane selects; lane j
// picks IA[col-j] when that bit exists, otherwise the zero input.
module multiplier_sequencer_column_select
    import multiplier_sequencer_pkg::*;
(
    input  logic [2:0] col,
    input  logic       run,
    output logic [2:0] ctrl_b0,
    output logic [2:0] ctrl_b1,
    output logic [2:0] ctrl_b2,
    output logic [2:0] ctrl_b3
);

    logic [2:0] sel [4];
    logic [3:0] diff [4];

    // Per-lane offset decode; out-of-range offsets select zero.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            diff[j] = {1'b0, col} - 4'(j);
            if (run && ({1'b0, col} >= 4'(j)) && (diff[j] <= 4'd3)) begin
                sel[j] = diff[j][2:0];
            end else begin
                sel[j] = SEL_ZERO;
            end
        end
    end

    assign ctrl_b0 = sel[0];
    assign ctrl_b1 = sel[1];
    assign ctrl_b2 = sel[2];
    assign ctrl_b3 = sel[3];

endmodule

// File: rtl/multiplier_sequencer.sv
// Sequences the 4x4 partial-product stage one column per cycle and
// accumulates the returned bits with a running carry into an 8-bit product.
module multiplier_sequencer
    import multiplier_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    multiplier_sequencer_if.slave  bus
);

    logic [1:0]        state;
    logic [2:0]        col;
    logic [1:0]        carry;
    logic [OP_W-1:0]   ia;
    logic [OP_W-1:0]   ib;
    logic [PROD_W-1:0] p;
    logic [2:0]        s;
    logic              accept;

    // Column sum never exceeds 6, so three bits hold it and carry fits in two.
    assign s      = popcount4(bus.pp) + {1'b0, carry};
    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_FIN));

    // Operation state, operand latches and product accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            col   <= 3'd0;
            carry <= 2'd0;
            ia    <= 4'd0;
            ib    <= 4'd0;
            p     <= 8'd0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (accept) begin
                        ia    <= bus.a;
                        ib    <= bus.b;
                        col   <= 3'd0;
                        carry <= 2'd0;
                        p     <= 8'd0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    p[col] <= s[0];
                    carry  <= s[2:1];
                    if (col == 3'(NUM_COLS - 1)) begin
                        // Final carry out of column 6 is at most 1: it is bit 7.
                        p[7]  <= s[1];
                        state <= ST_FIN;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    multiplier_sequencer_column_select u_column_select (
        .col     (col),
        .run     (state == ST_RUN),
        .ctrl_b0 (bus.ctrl_b0),
        .ctrl_b1 (bus.ctrl_b1),
        .ctrl_b2 (bus.ctrl_b2),
        .ctrl_b3 (bus.ctrl_b3)
    );

    assign bus.ia   = ia;
    assign bus.ib   = ib;
    assign bus.p    = p;
    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_FIN);

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench: sequencer plus a behavioural partial-product stage, checked every
// cycle against a cycle-count model of the operation and by literal spot checks.
module tb_multiplier_sequencer;

    logic clk;
    logic rst;

    multiplier_sequencer_if bus ();

    multiplier_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Partial-product stage: lane j outputs IA[sel] & IB[j], or 0 for sel 4.
    logic [2:0] stage_sel [4];
    assign stage_sel[0] = bus.ctrl_b0;
    assign stage_sel[1] = bus.ctrl_b1;
    assign stage_sel[2] = bus.ctrl_b2;
    assign stage_sel[3] = bus.ctrl_b3;

    always_comb begin
        bus.pp = 4'd0;
        for (int j = 0; j < 4; j++) begin
            if (stage_sel[j] <= 3'd3) begin
                bus.pp[j] = bus.ia[stage_sel[j][1:0]] & bus.ib[j];
            end else begin
                bus.pp[j] = 1'b0;
            end
        end
    end

    // Model: phase 0 idle, 1..7 column phase-1 in flight, 8 result cycle.
    int         phase;
    logic [3:0] m_ia, m_ib;
    logic [7:0] m_prod;
    logic       m_pvalid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 0;
            m_ia     <= 4'd0;
            m_ib     <= 4'd0;
            m_prod   <= 8'd0;
            m_pvalid <= 1'b1;
        end else if ((phase == 0 || phase == 8) && bus.start) begin
            phase    <= 1;
            m_ia     <= bus.a;
            m_ib     <= bus.b;
            m_prod   <= 8'(bus.a * bus.b);
            m_pvalid <= 1'b0;
        end else if (phase == 0 || phase == 8) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
            if (phase == 7) m_pvalid <= 1'b1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        int k, d;
        int ctrl_act [4];
        forever begin
            @(negedge clk);
            ctrl_act[0] = bus.ctrl_b0;
            ctrl_act[1] = bus.ctrl_b1;
            ctrl_act[2] = bus.ctrl_b2;
            ctrl_act[3] = bus.ctrl_b3;
            cmp("busy", bus.busy, (phase >= 1 && phase <= 7) ? 1 : 0);
            cmp("done", bus.done, (phase == 8) ? 1 : 0);
            cmp("ia", bus.ia, m_ia);
            cmp("ib", bus.ib, m_ib);
            k = phase - 1;
            for (int j = 0; j < 4; j++) begin
                d = k - j;
                if (phase >= 1 && phase <= 7 && d >= 0 && d <= 3)
                    cmp("ctrl", ctrl_act[j], d);
                else
                    cmp("ctrl", ctrl_act[j], 4);
            end
            if (m_pvalid && !(phase >= 1 && phase <= 7))
                cmp("p", bus.p, m_prod);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [3:0] av, input logic [3:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 12) begin
            step();
            cycles++;
        end
        if (!bus.done) cmp("done_timeout", 0, 1);
    endtask

    initial begin
        int cyc, nbusy;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        step();
        step();
        cmp("rst_p", bus.p, 0);
        cmp("rst_busy", bus.busy, 0);
        cmp("rst_done", bus.done, 0);
        cmp("rst_ctrl3", bus.ctrl_b3, 4);
        rst = 1'b0;
        step();

        // 15x15: exactly 7 busy cycles, DONE in the 8th cycle, P=225.
        go(4'd15, 4'd15);
        cyc = 0; nbusy = 0;
        while (!bus.done && cyc < 12) begin
            if (bus.busy) nbusy++;
            step();
            cyc++;
        end
        cmp("lat_15x15", cyc, 7);
        cmp("busy_cnt", nbusy, 7);
        cmp("p_15x15", bus.p, 8'hE1);
        step();

        // 9x5: lane selects at columns 3 and 6.
        go(4'd9, 4'd5);
        repeat (3) step();
        cmp("c3_b0", bus.ctrl_b0, 3);
        cmp("c3_b1", bus.ctrl_b1, 2);
        cmp("c3_b2", bus.ctrl_b2, 1);
        cmp("c3_b3", bus.ctrl_b3, 0);
        repeat (3) step();
        cmp("c6_b0", bus.ctrl_b0, 4);
        cmp("c6_b1", bus.ctrl_b1, 4);
        cmp("c6_b2", bus.ctrl_b2, 4);
        cmp("c6_b3", bus.ctrl_b3, 3);
        step();
        cmp("done_9x5", bus.done, 1);
        cmp("p_9x5", bus.p, 45);
        step();

        // Zero operands still produce a DONE pulse.
        go(4'd0, 4'd13);
        wait_done(cyc);
        cmp("p_0x13", bus.p, 0);
        step();
        go(4'd7, 4'd0);
        wait_done(cyc);
        cmp("p_7x0", bus.p, 0);
        step();

        // START during RUN is ignored.
        go(4'd3, 4'd3);
        step();
        go(4'd15, 4'd15);
        wait_done(cyc);
        cmp("p_3x3", bus.p, 9);
        cmp("ign_ia", bus.ia, 3);
        step();

        // START held: back-to-back acceptance at FIN.
        bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd7;
        step();
        wait_done(cyc);
        cmp("p_6x7", bus.p, 42);
        bus.a = 4'd2; bus.b = 4'd11;
        step();
        cmp("b2b_busy", bus.busy, 1);
        wait_done(cyc);
        cmp("p_2x11", bus.p, 22);
        bus.start = 1'b0;
        step();

        // Reset at column 4 aborts with no DONE.
        go(4'd12, 4'd10);
        repeat (4) step();
        rst = 1'b1;
        #1;
        cmp("abort_busy", bus.busy, 0);
        cmp("abort_p", bus.p, 0);
        cmp("abort_ia", bus.ia, 0);
        cmp("abort_ctrl0", bus.ctrl_b0, 4);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            cmp("abort_nodone", bus.done, 0);
        end

        // Exhaustive operand sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                go(4'(i), 4'(j));
                wait_done(cyc);
                cmp("sweep", bus.p, i * j);
            end
        end
        step();

        // Random START/operand traffic checked by the per-cycle compare.
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a     = 4'($urandom_range(0, 15));
            bus.b     = 4'($urandom_range(0, 15));
            step();
        end
        bus.start = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier_sequencer.md
# multiplier_sequencer

Sequential controller and column accumulator for the 4x4 partial-product stage. It latches two 4-bit operands and drives the stage's operand and lane-select inputs one product column per cycle. It sums the four returned partial-product bits with a running carry and assembles the 8-bit unsigned product. The stage is purely combinational and sits between this block's outputs and its PP input.

## Interface

Parameters: none. Widths are fixed at 4x4 -> 8.

Ports:
- CLK  in  1  single clock, rising edge. One clock; reset is asynchronous and active-high.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request a multiply. Sampled on the rising edge of CLK.
- A  in  4  multiplicand, captured with START.
- B  in  4  multiplier, captured with START.
- IA  out  4  registered A, driven to the stage's IA.
- IB  out  4  registered B, driven to the stage's IB.
- CTRL_B0..CTRL_B3  out  3 each  lane select for the stage: 0..3 selects IA[n], 4 selects zero.
- PP  in  4  partial-product bits returned by the stage: PP[0]=OA, PP[1]=OB, PP[2]=OC, PP[3]=OD.
- BUSY  out  1  high while columns are being processed.
- DONE  out  1  one-cycle pulse when P is valid.
- P  out  8  product. Held until the next accepted START.

## Operation

- States:
  - IDLE: waiting for START.
  - RUN: processing columns 0..6.
  - FIN: one cycle, DONE=1.
- IDLE + START: latch A/B into IA/IB, clear col, carry and P, go to RUN.
- IDLE + no START: stay in IDLE.
- Lane select in RUN, column k, lane j: CTRL_Bj = k-j when 0 <= k-j <= 3, otherwise 4.
- Lane select in IDLE and FIN: all CTRL_Bj = 4.
- Codes 5..7 are never driven.
- Each RUN cycle, with s = popcount(PP) + carry:
  - P[k] <= s[0]
  - carry <= s >> 1
  - col <= col+1
- Arithmetic widths:
  - s is 3 bits; maximum 6, at column 3 or 4.
  - carry is 2 bits; maximum 3.
- After column 6: P[7] <= carry_next, which is always 0 or 1. Go to FIN.
- FIN:
  - DONE=1, BUSY=0.
  - START in this cycle is accepted exactly as in IDLE: next state RUN.
  - Without START, next state IDLE.
- START while in RUN is ignored. Operands and progress are not affected.
- A and B are sampled only at acceptance. Later changes have no effect.
- P is unsigned. It is partially updated during RUN and is valid only when DONE=1 or in IDLE after FIN.

## Timing

- Reset values (asynchronous, immediate):
  - state=IDLE, col=0, carry=0
  - P=0, IA=0, IB=0
  - CTRL_B0..3=4
  - BUSY=0, DONE=0
- RST asserted mid-RUN aborts the operation. Outputs return to reset values. No DONE is produced.
- Latency: START sampled at edge 0 -> RUN for edges 1..7 (7 cycles) -> DONE=1 in cycle 8. P is valid in that same cycle.
- Throughput: one product per 8 cycles with START held high. Back-to-back starts are accepted in the FIN cycle.
- BUSY is high for exactly 7 cycles per operation.
- CTRL and IA/IB are registered or decoded from registered state. The PP round trip through the stage is combinational within one cycle.

## Structure

- Shared package contents:
  - SEL_ZERO = 3'd4
  - NUM_COLS = 7
  - state encoding IDLE/RUN/FIN
  - operand width 4, product width 8
- Sub-module: column_select. Maps the 3-bit column index to the four 3-bit lane selects. Purely combinational, with one instance.
- Popcount and carry add stay inline in multiplier_sequencer.
- The bench wraps multiplier_sequencer and the existing partial-product stage in a top that connects IA/IB/CTRL/PP.

## Test plan

- Reset, then START with A=15, B=15 -> DONE in the 8th cycle after the START edge, P=8'hE1 (225), BUSY high for 7 cycles.
- A=9, B=5 -> P=45. CTRL sequence at column 3 is (3,2,1,0); at column 6 it is (4,4,4,3).
- A=0, B=13, then A=7, B=0 -> P=0 both times. DONE still pulses.
- START with A=3, B=3, then pulse START with A=15, B=15 during RUN -> P=9. The second request is ignored.
- START held high continuously with A=6, B=7, then A=2, B=11 presented at FIN -> P=42, then P=22 with no idle cycle between operations.
- Assert RST at column 4 -> all outputs at reset values immediately, no DONE. Then exhaustively check all 256 A×B pairs.
